// File: rtl/mul_seq_ctrl.sv
// RV32M multiply sequencer in front of the combinational signed 32x32->64
// Wallace tree. One operation is in flight at a time: operands are registered
// onto mt_a/mt_b and held while the tree settles, the signed product is
// captured, then corrected for unsigned operands before the requested
// 32-bit half is returned on the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request side only offers ready in IDLE, and the response
// side keeps rsp_valid and rsp_result stable until rsp_ready is seen. flush
// suppresses both transfers in the cycle it is high.
module mul_seq_ctrl #(
    parameter int TREE_CYCLES = 5,
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic [31:0] mt_a,
    output logic [31:0] mt_b,
    input  logic [63:0] mt_f,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  dbg_state
);

    localparam int CW = (TREE_CYCLES > 1) ? $clog2(TREE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(TREE_CYCLES - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt;
    logic [63:0]   prod_q;

    logic          zero_hit;
    logic [31:0]   corr;
    logic [63:0]   prod_fix;
    logic [31:0]   res_sel;

    assign req_ready = (state == S_IDLE) && !rst && !flush;
    assign dbg_state = state;

    // Unsigned-operand correction on top of the signed tree product. Only the
    // low 32 bits of the correction reach the product after the <<32, so the
    // carry of the MULHU sum is dropped here. mt_a/mt_b still hold rs1/rs2.
    always_comb begin
        zero_hit = BYPASS_ZERO && ((req_rs1 == 32'h0) || (req_rs2 == 32'h0));
        corr     = 32'h0;
        case (op_q)
            OP_MULHSU: corr = mt_b[31] ? mt_a : 32'h0;
            OP_MULHU:  corr = (mt_a[31] ? mt_b : 32'h0) + (mt_b[31] ? mt_a : 32'h0);
            default:   corr = 32'h0;
        endcase
        prod_fix = prod_q + {corr, 32'h0};
        res_sel  = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    end

    // Sequencer FSM with registered operands, product and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= 2'b00;
            mt_a       <= 32'h0;
            mt_b       <= 32'h0;
            prod_q     <= 64'h0;
            cnt        <= '0;
            rsp_result <= 32'h0;
            rsp_valid  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        mt_a <= req_rs1;
                        mt_b <= req_rs2;
                        if (zero_hit) begin
                            rsp_result <= 32'h0;
                            rsp_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        prod_q <= mt_f;
                        state  <= S_FIX;
                    end
                end
                S_FIX: begin
                    prod_q     <= prod_fix;
                    rsp_result <= res_sel;
                    rsp_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl. The multiplier tree is modelled as a signed
// product that only becomes valid once mt_a/mt_b have been stable for
// TREE_CYCLES cycles (a garbage pattern stands in for X before that).
module tb_mul_seq_ctrl;

    localparam int TC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_rs1 = 32'h0;
    logic [31:0] req_rs2 = 32'h0;
    logic [31:0] mt_a;
    logic [31:0] mt_b;
    logic [63:0] mt_f;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    // Scoreboard and reference state
    logic [31:0] exp_q[$];
    logic [31:0] exp_a = 32'h0;
    logic [31:0] exp_b = 32'h0;
    int          wait_left = 0;
    bit          armed = 1'b0;
    bit          rst_prev = 1'b0;
    int          f_age = 0;
    logic [63:0] prev_ab = 64'h0;

    mul_seq_ctrl #(.TREE_CYCLES(TC), .BYPASS_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .mt_a       (mt_a),
        .mt_b       (mt_b),
        .mt_f       (mt_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Tree stand-in: correct signed product only after the settle time
    assign mt_f = (f_age >= TC - 1) ? ({{32{mt_a[31]}}, mt_a} * {{32{mt_b[31]}}, mt_b})
                                    : 64'hBAD0_BAD0_BAD0_BAD0;

    // Architectural RV32M result from full-width arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = (op == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
        xb = (op == 2'b00 || op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the reference, then advance the reference
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst_prev) begin
                    chk("rst_mt_a", mt_a, 0);
                    chk("rst_mt_b", mt_b, 0);
                    chk("rst_rsp_result", rsp_result, 0);
                    chk("rst_rsp_valid", rsp_valid, 0);
                end
                chk("req_ready", req_ready, (exp_q.size() == 0) && !rst && !flush);
                chk("rsp_valid", rsp_valid, (exp_q.size() != 0) && (wait_left == 0));
                if (exp_q.size() != 0) begin
                    chk("mt_a_hold", mt_a, exp_a);
                    chk("mt_b_hold", mt_b, exp_b);
                    if (rsp_valid) chk("rsp_result", rsp_result, exp_q[0]);
                end
            end
            if ({mt_a, mt_b} !== prev_ab) f_age = 0;
            else if (f_age < 1000) f_age++;
            prev_ab = {mt_a, mt_b};
            rst_prev = rst;
            if (rst) begin
                armed = 1'b1;
                exp_q.delete();
            end else if (flush) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                if (wait_left == 0) begin
                    if (rsp_ready) void'(exp_q.pop_front());
                end else begin
                    wait_left--;
                end
            end else if (req_valid) begin
                exp_q.push_back(ref_result(req_op, req_rs1, req_rs2));
                exp_a = req_rs1;
                exp_b = req_rs2;
                wait_left = (req_rs1 == 32'h0 || req_rs2 == 32'h0) ? 0 : TC + 1;
            end
        end
    end

    // Issue one request, check result and latency, then complete the handshake
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lat_exp, input string name);
        int lat;
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
        req_rs1 = $urandom;
        req_rs2 = $urandom;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk(name, rsp_result, lit);
            chk({name, "_lat"}, lat, lat_exp);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(2'b00, 32'd5, 32'd6, 32'd30, 7, "mul_5x6");
        run_op(2'b00, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFE2, 7, "mul_m5x6");
        run_op(2'b01, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF, 7, "mulh_m5x6");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, "mulhu_max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 7, "mul_max");
        run_op(2'b10, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 7, "mulhsu_2xmax");
        run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 7, "mulhsu_m1x2");
        run_op(2'b11, 32'h8000_0000, 32'd4, 32'h0000_0002, 7, "mulhu_2p31x4");

        // Zero bypass, then a stalled consumer for 10 cycles
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h0; req_rs2 = 32'h1234;
        @(posedge clk); #1;
        req_rs1 = 32'h77; req_rs2 = 32'h99;
        @(negedge clk);
        chk("bypass_valid", rsp_valid, 1);
        chk("bypass_result", rsp_result, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_result", rsp_result, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bypass_drop", rsp_valid, 0);

        // Flush in WAIT cycle 2, with a competing request that must be ignored
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h11; req_rs2 = 32'h22;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_rs1 = 32'h9; req_rs2 = 32'h9;
        @(negedge clk);
        chk("flush_req_ready", req_ready, 0);
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle", req_ready, 1);
        chk("flush_mt_a", mt_a, 32'h11);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("flush_no_rsp", rsp_valid, 0);
        end

        // Flush in DONE together with rsp_ready
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'h5; req_rs2 = 32'h0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("done_flush_pre", rsp_valid, 1);
        @(posedge clk); #1 flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("done_flush_valid", rsp_valid, 0);
        chk("done_flush_idle", req_ready, 1);

        // Reset in the middle of WAIT
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h55; req_rs2 = 32'h66;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_mt_a", mt_a, 0);
        chk("midrst_rsp_result", rsp_result, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        repeat (3) @(negedge clk);
        run_op(2'b00, 32'd7, 32'd3, 32'd21, 7, "mul_7x3");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
